// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the combinational instruction memory
// and registers the returned word into the IF/ID register for decode.
//
// state | meaning
// BOOT  | single bubble cycle after reset release; a redirect is still accepted
// RUN   | normal fetch: redirect > stall > range fault > sequential fetch
// FAULT | PC left the legal range; fetch halted until reset
module fetch_stage #(
  parameter int WIDTH     = 32,
  parameter int PC_W      = 32,
  parameter int MEM_DEPTH = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [PC_W-1:0]  imem_pc,
  input  logic [WIDTH-1:0] imem_inst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_inst,
  output logic [PC_W-1:0]  if_pc,
  output logic             fetch_fault
);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  localparam logic [PC_W-1:0] DEPTH_PC = PC_W'(MEM_DEPTH);

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc, pc_nxt;
  logic             valid_nxt;
  logic [WIDTH-1:0] inst_nxt;
  logic [PC_W-1:0]  ifpc_nxt;
  logic             fault_nxt;

  assign imem_pc = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_inst     <= '0;
      if_pc       <= '0;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      if_valid    <= valid_nxt;
      if_inst     <= inst_nxt;
      if_pc       <= ifpc_nxt;
      fetch_fault <= fault_nxt;
    end
  end

  // imem_inst is only read on a real fetch, so X outside the legal range never lands in IF/ID
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid_nxt = if_valid;
    inst_nxt  = if_inst;
    ifpc_nxt  = if_pc;
    fault_nxt = fetch_fault;
    unique case (state)
      BOOT: begin
        valid_nxt = 1'b0;
        state_nxt = RUN;
        if (redirect_valid) pc_nxt = redirect_pc;
      end
      RUN: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          valid_nxt = 1'b0;
          if (redirect_pc >= DEPTH_PC) begin
            fault_nxt = 1'b1;
            state_nxt = FAULT;
          end
        end else if (stall) begin
          pc_nxt = pc;
        end else if (pc >= DEPTH_PC) begin
          valid_nxt = 1'b0;
          fault_nxt = 1'b1;
          state_nxt = FAULT;
        end else begin
          inst_nxt  = imem_inst;
          ifpc_nxt  = pc;
          valid_nxt = 1'b1;
          pc_nxt    = pc + 1'b1;
        end
      end
      FAULT: begin
        valid_nxt = 1'b0;
        fault_nxt = 1'b1;
      end
      default: state_nxt = BOOT;
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: small program in a bench-side memory, with
// stall, redirect, range-fault and async-reset scenarios checked edge by edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        fetch_fault;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mem [16];

  fetch_stage #(.WIDTH(32), .PC_W(32), .MEM_DEPTH(16), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_inst(imem_inst),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // out-of-range reads return a poison word that must never reach if_inst
  always_comb begin
    imem_inst = 32'hBAD0_BAD0;
    if (imem_pc < 32'd16) imem_inst = mem[imem_pc[3:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetched(input string tag, input int idx);
    chk({tag, " valid"}, 32'(if_valid), 32'd1);
    chk({tag, " if_pc"}, if_pc, 32'(idx));
    chk({tag, " inst"},  if_inst, mem[idx]);
  endtask

  initial begin
    // MOV opcode 5'd1 in the top bits, distinct immediates below
    for (int i = 0; i < 16; i++) mem[i] = {5'd1, 27'(32'h100 + i * 3)};
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    chk("rst valid", 32'(if_valid), 32'd0);
    chk("rst imem_pc", imem_pc, 32'd0);
    chk("rst if_pc", if_pc, 32'd0);
    chk("rst if_inst", if_inst, 32'd0);
    chk("rst fault", 32'(fetch_fault), 32'd0);
    repeat (2) tick();
    #3 rst_n = 1'b1;

    // 1: BOOT bubble then sequential fetch
    tick();
    chk("boot valid", 32'(if_valid), 32'd0);
    chk("boot imem_pc", imem_pc, 32'd0);
    tick(); fetched("seq0", 0);
    tick(); fetched("seq1", 1);
    tick(); fetched("seq2", 2);
    chk("seq imem_pc", imem_pc, 32'd3);

    // 2: stall 3 cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      fetched("stall", 2);
      chk("stall imem_pc", imem_pc, 32'd3);
    end
    stall = 1'b0;
    tick(); fetched("resume3", 3);
    tick(); fetched("run4", 4);
    tick(); fetched("run5", 5);

    // 3: loop-back redirect to 3
    redirect_valid = 1'b1; redirect_pc = 32'd3;
    tick();
    redirect_valid = 1'b0;
    chk("redir squash", 32'(if_valid), 32'd0);
    chk("redir imem_pc", imem_pc, 32'd3);
    tick(); fetched("redir tgt", 3);

    // 4: redirect beats stall; then stall on a bubble
    redirect_valid = 1'b1; redirect_pc = 32'd0; stall = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("rs valid", 32'(if_valid), 32'd0);
    chk("rs imem_pc", imem_pc, 32'd0);
    tick();
    stall = 1'b0;
    chk("bubble stall valid", 32'(if_valid), 32'd0);
    chk("bubble stall imem_pc", imem_pc, 32'd0);
    tick(); fetched("after bubble", 0);

    // 5: run off the end
    redirect_valid = 1'b1; redirect_pc = 32'd14;
    tick();
    redirect_valid = 1'b0;
    chk("to14 imem_pc", imem_pc, 32'd14);
    tick(); fetched("run14", 14);
    tick(); fetched("run15", 15);
    chk("fault pre", 32'(fetch_fault), 32'd0);
    tick();
    chk("end fault", 32'(fetch_fault), 32'd1);
    chk("end valid", 32'(if_valid), 32'd0);
    chk("end imem_pc", imem_pc, 32'd16);
    chk("end if_inst", if_inst, mem[15]);
    redirect_valid = 1'b1; redirect_pc = 32'd2;
    tick();
    redirect_valid = 1'b0;
    chk("fault redir imem_pc", imem_pc, 32'd16);
    chk("fault redir fault", 32'(fetch_fault), 32'd1);
    chk("fault redir valid", 32'(if_valid), 32'd0);

    // 6: async reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk("async fault", 32'(fetch_fault), 32'd0);
    chk("async imem_pc", imem_pc, 32'd0);
    chk("async if_inst", if_inst, 32'd0);
    chk("async if_pc", if_pc, 32'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("reboot valid", 32'(if_valid), 32'd0);
    tick(); fetched("reboot0", 0);

    // redirect out of range from RUN
    redirect_valid = 1'b1; redirect_pc = 32'd20;
    tick();
    chk("far fault", 32'(fetch_fault), 32'd1);
    chk("far valid", 32'(if_valid), 32'd0);
    chk("far imem_pc", imem_pc, 32'd20);
    redirect_pc = 32'd3;
    tick();
    redirect_valid = 1'b0;
    chk("far hold imem_pc", imem_pc, 32'd20);

    // redirect during BOOT is accepted
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'd7;
    tick();
    redirect_valid = 1'b0;
    chk("boot redir valid", 32'(if_valid), 32'd0);
    chk("boot redir imem_pc", imem_pc, 32'd7);
    tick(); fetched("boot redir tgt", 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
